// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and parity modes.
// Used by the transmitter; the receiver can import the same package.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts system clocks within one UART bit.
// bit_end marks the last cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW =
    ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_end = (count_q == LAST);

  // Next count: held at zero by clear, wraps on the last cycle.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_end) count_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/uart_transmitter_custom.sv
// UART transmitter: one-entry holding register feeding a frame FSM.
// Frames go out back-to-back when the next byte is already held.
module uart_transmitter_custom
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam bit PAR_EN   = (PARITY_MODE == PARITY_EVEN) ||
                            (PARITY_MODE == PARITY_ODD);
  localparam bit PAR_ODD  = (PARITY_MODE == PARITY_ODD);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       par_q, par_d;
  logic       serial_q, serial_d;
  logic       done_q, done_d;
  logic       timer_clear;
  logic       bit_end;
  logic       load;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  assign tx_ready  = !hold_valid_q;
  assign tx_serial = serial_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign tx_done   = done_q;

  // Frame sequencing; the line level is computed one edge ahead.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    par_d       = par_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    load        = 1'b0;
    timer_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        serial_d    = 1'b1;
        timer_clear = 1'b1;
        if (hold_valid_q) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          serial_d  = shift_q[0];
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PAR_EN) begin
              state_d  = ST_PARITY;
              serial_d = par_q;
            end else begin
              state_d    = ST_STOP;
              serial_d   = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          serial_d   = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!TWO_STOP || stop_idx_q) begin
            done_d = 1'b1;
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              serial_d = 1'b1;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        serial_d    = 1'b1;
        timer_clear = 1'b1;
      end
    endcase
    if (load) begin
      state_d  = ST_START;
      serial_d = 1'b0;
      shift_d  = hold_q;
      par_d    = PAR_ODD ? ~^hold_q : ^hold_q;
    end
  end

  // Holding register: accept when empty, release on shifter load.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end else if (tx_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_d       = tx_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      par_q        <= 1'b0;
      serial_q     <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      par_q        <= par_d;
      serial_q     <= serial_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter_custom.sv
// Bench for uart_transmitter_custom: four parameter sets share one
// stimulus driver; per-instance monitors decode frames off the line.
module tb_uart_transmitter_custom;

  localparam int NI = 4;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] t;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] v;
  logic [7:0]    d [NI];
  logic [NI-1:0] r, s, b, dn;

  ent_t        exp_q [NI][$];
  logic [7:0]  dir_q [NI][$];
  int unsigned pend  [NI];
  int unsigned cyc = 0;
  bit          rnd_en = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter_custom #(
    .CLKS_PER_BIT(10), .PARITY_MODE(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(r[0]), .tx_serial(s[0]), .tx_busy(b[0]),
    .tx_done(dn[0])
  );

  uart_transmitter_custom #(
    .CLKS_PER_BIT(10), .PARITY_MODE(1), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(r[1]), .tx_serial(s[1]), .tx_busy(b[1]),
    .tx_done(dn[1])
  );

  uart_transmitter_custom #(
    .CLKS_PER_BIT(5), .PARITY_MODE(2), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(r[2]), .tx_serial(s[2]), .tx_busy(b[2]),
    .tx_done(dn[2])
  );

  uart_transmitter_custom #(
    .CLKS_PER_BIT(2), .PARITY_MODE(3), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(v[3]),
    .tx_ready(r[3]), .tx_serial(s[3]), .tx_busy(b[3]),
    .tx_done(dn[3])
  );

  function automatic int cpb_of(input int k);
    case (k)
      0, 1:    return 10;
      2:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int pm_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sb_of(input int k);
    return (k >= 2) ? 2 : 1;
  endfunction

  function automatic int par_on(input int k);
    return (pm_of(k) == 1 || pm_of(k) == 2) ? 1 : 0;
  endfunction

  function automatic int flen(input int k);
    return (9 + par_on(k) + sb_of(k)) * cpb_of(k);
  endfunction

  // Expected line level for bit slot idx of a frame carrying db.
  function automatic logic frame_bit(input int k, input logic [7:0] db,
                                     input int idx);
    int ones;
    ones = $countones(db);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return db[idx-1];
    if (par_on(k) == 1 && idx == 9) begin
      if (pm_of(k) == 1) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  function automatic void chk(input string nm, input int k,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d t=%0t got=%0h want=%0h",
               nm, k, $time, act, exp);
    end
  endfunction

  // Called at the first low sample of a frame; returns after the
  // sample where tx_done is due, or early if reset hits.
  task automatic frame(input int k);
    ent_t        e;
    int          len, c, o, bad_off;
    bit          bad;
    logic        fb;
    int unsigned st, want;
    len = flen(k);
    c   = cpb_of(k);
    st  = cyc;
    if (exp_q[k].size() == 0) begin
      chk("unexpected_frame", k, 1, 0);
      e.data = 8'h00;
      e.t    = cyc - 1;
    end else begin
      e = exp_q[k].pop_front();
    end
    want = (e.t + 1 > pend[k]) ? e.t + 1 : pend[k];
    chk("start_cycle", k, st, want);
    bad     = 1'b0;
    bad_off = -1;
    for (o = 0; o < len; o++) begin
      if (o > 0) begin
        @(posedge clk); #1;
      end
      if (rst) return;
      fb = frame_bit(k, e.data, o / c);
      if (o % c == c / 2) chk("bit_centre", k, s[k], fb);
      if (!bad && (s[k] !== fb || b[k] !== 1'b1 ||
                   (o > 0 && dn[k] !== 1'b0))) begin
        bad     = 1'b1;
        bad_off = o;
      end
    end
    chk("frame_first_bad_offset", k, bad_off, -1);
    pend[k] = st + len;
    @(posedge clk); #1;
    if (rst) return;
    chk("done_pulse", k, dn[k], 1);
  endtask

  task automatic mon(input int k);
    bit in_f;
    forever begin
      @(posedge clk); #1;
      in_f = 1'b0;
      while (!rst && !s[k]) begin
        frame(k);
        in_f = 1'b1;
      end
      if (rst) begin
        exp_q[k].delete();
        pend[k] = 0;
      end else if (!in_f) begin
        chk("idle_busy", k, b[k], 0);
        chk("idle_done", k, dn[k], 0);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  // One driver cycle; whatever is valid with ready high at this
  // negedge is taken at the next rising edge.
  task automatic step();
    ent_t e;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      d[k] = 8'($urandom);
      if (rst) begin
        v[k] = 1'b0;
      end else if (dir_q[k].size() > 0) begin
        v[k] = 1'b1;
        d[k] = dir_q[k][0];
      end else begin
        v[k] = rnd_en && ($urandom_range(0, 3) == 0);
      end
      if (v[k] && r[k]) begin
        e.data = d[k];
        e.t    = cyc + 1;
        exp_q[k].push_back(e);
        if (dir_q[k].size() > 0) void'(dir_q[k].pop_front());
      end
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < NI; k++)
      if (dir_q[k].size() > 0 || exp_q[k].size() > 0) return 1'b1;
    return |b;
  endfunction

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (n < lim && pending()) begin
      step();
      n++;
    end
    chk("drain_timeout", 0, (n < lim) ? 0 : 1, 0);
    repeat (3) step();
  endtask

  task automatic send_all(input logic [7:0] x);
    for (int k = 0; k < NI; k++) dir_q[k].push_back(x);
  endtask

  task automatic reset_check(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_serial"}, k, s[k], 1);
      chk({tag, "_ready"},  k, r[k], 1);
      chk({tag, "_busy"},   k, b[k], 0);
      chk({tag, "_done"},   k, dn[k], 0);
    end
  endtask

  initial begin
    int n;
    v = '0;
    for (int k = 0; k < NI; k++) begin
      d[k]    = 8'h00;
      pend[k] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    reset_check("rst");
    rst = 1'b0;

    send_all(8'hA5);
    drain(2000);
    send_all(8'h01);
    send_all(8'h80);
    drain(2000);
    send_all(8'hFF);
    send_all(8'h3C);
    drain(2000);

    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0;
    drain(4000);

    send_all(8'h5A);
    n = 0;
    while (n < 100 && !b[0]) begin
      step();
      n++;
    end
    chk("wait_busy_timeout", 0, (n < 100) ? 0 : 1, 0);
    repeat (43) step();
    rst = 1'b1;
    step();
    reset_check("midrst");
    rst = 1'b0;
    for (int k = 0; k < NI; k++) dir_q[k].delete();
    send_all(8'hC3);
    drain(2000);

    repeat (1000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
